// File: rtl/output_queue_writer.sv
// output_queue_writer
//
// Front end of the UART output path. Takes byte or word output requests from
// the core and writes them one byte per cycle into the 512-entry circular send
// queue. Words go out MSB first. The block owns the queue storage and the tail
// pointer. output_manager drains the queue and returns its head pointer.
//
// Ports
//   CLK           in   sole clock, rising edge
//   INITIALIZE    in   synchronous active-high reset
//   out_valid     in   core presents an output request
//   out_word      in   1: emit all 4 bytes of out_data MSB first, 0: out_data[7:0] only
//   out_data      in   32-bit payload, sampled only on the accept cycle
//   out_ready     out  request accepted when out_valid && out_ready
//   queue_s       in   head pointer from output_manager
//   send_queue    out  512 x 8-bit queue storage
//   queue_t       out  tail pointer (next free slot)
//   bytes_written out  bytes enqueued since reset, wraps mod 2^32

module output_queue_writer (
  input  logic        CLK,
  input  logic        INITIALIZE,
  input  logic        out_valid,
  input  logic        out_word,
  input  logic [31:0] out_data,
  output logic        out_ready,
  input  logic [8:0]  queue_s,
  output logic [7:0]  send_queue [512],
  output logic [8:0]  queue_t,
  output logic [31:0] bytes_written
);

  typedef enum logic {StIdle, StDrain} state_e;

  state_e      state_q, state_d;
  logic [1:0]  remaining_q, remaining_d;
  logic [23:0] pending_q, pending_d;
  logic [8:0]  queue_t_q, queue_t_d;
  logic [31:0] bytes_written_q, bytes_written_d;

  logic        full;
  logic        wr_en;
  logic [7:0]  wr_data;

  // One slot is kept free so that full and empty stay distinguishable.
  // queue_s only reaches storage writes through this term.
  assign full      = (queue_t_q + 9'd1) == queue_s;
  assign out_ready = (state_q == StIdle) && !full;

  always_comb begin
    state_d         = state_q;
    remaining_d     = remaining_q;
    pending_d       = pending_q;
    queue_t_d       = queue_t_q;
    bytes_written_d = bytes_written_q;
    wr_en           = 1'b0;
    wr_data         = 8'h00;

    unique case (state_q)
      StIdle: begin
        if (out_valid && out_ready) begin
          wr_en = 1'b1;
          if (out_word) begin
            wr_data     = out_data[31:24];
            pending_d   = out_data[23:0];
            remaining_d = 2'd3;
            state_d     = StDrain;
          end else begin
            wr_data = out_data[7:0];
          end
        end
      end
      StDrain: begin
        // A full queue just holds the word; nothing moves until queue_s advances.
        if (!full) begin
          wr_en       = 1'b1;
          wr_data     = pending_q[23:16];
          pending_d   = {pending_q[15:0], 8'h00};
          remaining_d = remaining_q - 2'd1;
          if (remaining_q == 2'd1) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (wr_en) begin
      queue_t_d       = queue_t_q + 9'd1;
      bytes_written_d = bytes_written_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (INITIALIZE) begin
      state_q         <= StIdle;
      remaining_q     <= 2'd0;
      pending_q       <= 24'h0;
      queue_t_q       <= 9'd0;
      bytes_written_q <= 32'd0;
    end else begin
      state_q         <= state_d;
      remaining_q     <= remaining_d;
      pending_q       <= pending_d;
      queue_t_q       <= queue_t_d;
      bytes_written_q <= bytes_written_d;
    end
  end

  // Storage is not cleared on reset. A write that would coincide with reset
  // (an interrupted drain) is suppressed so discarded bytes never land.
  always_ff @(posedge CLK) begin
    if (wr_en && !INITIALIZE) begin
      send_queue[queue_t_q] <= wr_data;
    end
  end

  assign queue_t       = queue_t_q;
  assign bytes_written = bytes_written_q;

endmodule

// File: tb/tb_output_queue_writer.sv
module tb_output_queue_writer;

  logic        CLK;
  logic        INITIALIZE;
  logic        out_valid;
  logic        out_word;
  logic [31:0] out_data;
  logic        out_ready;
  logic [8:0]  queue_s;
  logic [7:0]  sq [512];
  logic [8:0]  queue_t;
  logic [31:0] bytes_written;

  int n_cmp = 0;
  int n_err = 0;

  output_queue_writer dut (
    .CLK           (CLK),
    .INITIALIZE    (INITIALIZE),
    .out_valid     (out_valid),
    .out_word      (out_word),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .queue_s       (queue_s),
    .send_queue    (sq),
    .queue_t       (queue_t),
    .bytes_written (bytes_written)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    INITIALIZE = 1'b1;
    out_valid  = 1'b0;
    out_word   = 1'b0;
    out_data   = 32'h0;
    queue_s    = 9'd0;
    step();
    step();
    INITIALIZE = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (queue_t !== 9'd0) begin n_err++;
      $display("FAIL reset_queue_t got %0d want 0", queue_t); end
    n_cmp++; if (bytes_written !== 32'd0) begin n_err++;
      $display("FAIL reset_bytes got %0d want 0", bytes_written); end
    n_cmp++; if (out_ready !== 1'b1) begin n_err++;
      $display("FAIL reset_ready got %b want 1", out_ready); end
  endtask

  task automatic test_byte();
    out_valid = 1'b1; out_word = 1'b0; out_data = 32'hFFFF_FF41;
    step();
    out_valid = 1'b0;
    n_cmp++; if (sq[0] !== 8'h41) begin n_err++;
      $display("FAIL byte_slot0 got %h want 41", sq[0]); end
    n_cmp++; if (queue_t !== 9'd1) begin n_err++;
      $display("FAIL byte_queue_t got %0d want 1", queue_t); end
    n_cmp++; if (bytes_written !== 32'd1) begin n_err++;
      $display("FAIL byte_bytes got %0d want 1", bytes_written); end
    n_cmp++; if (out_ready !== 1'b1) begin n_err++;
      $display("FAIL byte_ready got %b want 1", out_ready); end
  endtask

  task automatic test_word();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hDE; exp_b[1] = 8'hAD; exp_b[2] = 8'hBE; exp_b[3] = 8'hEF;
    do_reset();
    out_valid = 1'b1; out_word = 1'b1; out_data = 32'hDEAD_BEEF;
    step();
    out_valid = 1'b0; out_data = 32'h0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (sq[i] !== exp_b[i]) begin n_err++;
        $display("FAIL word_slot%0d got %h want %h", i, sq[i], exp_b[i]); end
      n_cmp++; if (queue_t !== 9'(i + 1)) begin n_err++;
        $display("FAIL word_queue_t%0d got %0d want %0d", i, queue_t, i + 1); end
      n_cmp++; if (out_ready !== (i == 3)) begin n_err++;
        $display("FAIL word_ready%0d got %b want %b", i, out_ready, i == 3); end
      if (i < 3) step();
    end
    n_cmp++; if (bytes_written !== 32'd4) begin n_err++;
      $display("FAIL word_bytes got %0d want 4", bytes_written); end
  endtask

  task automatic test_full();
    do_reset();
    out_valid = 1'b1; out_word = 1'b0;
    for (int i = 0; i < 511; i++) begin
      out_data = 32'(i);
      step();
    end
    n_cmp++; if (queue_t !== 9'd511) begin n_err++;
      $display("FAIL full_queue_t got %0d want 511", queue_t); end
    n_cmp++; if (out_ready !== 1'b0) begin n_err++;
      $display("FAIL full_ready got %b want 0", out_ready); end
    out_data = 32'h0000_00AA;
    step(); step(); step();
    n_cmp++; if (queue_t !== 9'd511) begin n_err++;
      $display("FAIL full_hold_queue_t got %0d want 511", queue_t); end
    n_cmp++; if (bytes_written !== 32'd511) begin n_err++;
      $display("FAIL full_hold_bytes got %0d want 511", bytes_written); end
    n_cmp++; if (sq[510] !== 8'hFE) begin n_err++;
      $display("FAIL full_slot510 got %h want fe", sq[510]); end
    n_cmp++; if (sq[0] !== 8'h00) begin n_err++;
      $display("FAIL full_slot0 got %h want 00", sq[0]); end
    queue_s = 9'd1;
    #1;
    n_cmp++; if (out_ready !== 1'b1) begin n_err++;
      $display("FAIL full_release_ready got %b want 1", out_ready); end
    step();
    out_valid = 1'b0;
    n_cmp++; if (queue_t !== 9'd0) begin n_err++;
      $display("FAIL full_wrap_queue_t got %0d want 0", queue_t); end
    n_cmp++; if (sq[511] !== 8'hAA) begin n_err++;
      $display("FAIL full_slot511 got %h want aa", sq[511]); end
    n_cmp++; if (bytes_written !== 32'd512) begin n_err++;
      $display("FAIL full_bytes got %0d want 512", bytes_written); end
  endtask

  task automatic test_wrap_word();
    do_reset();
    out_valid = 1'b1; out_word = 1'b0; out_data = 32'h0000_005A;
    for (int i = 0; i < 509; i++) step();
    out_word = 1'b1; out_data = 32'h0102_0304;
    step();
    out_valid = 1'b0; out_word = 1'b0; out_data = 32'h0;
    step();
    n_cmp++; if (sq[509] !== 8'h01 || sq[510] !== 8'h02) begin n_err++;
      $display("FAIL wrap_head_bytes got %h %h want 01 02", sq[509], sq[510]); end
    step(); step(); step();
    n_cmp++; if (queue_t !== 9'd511) begin n_err++;
      $display("FAIL wrap_stall_queue_t got %0d want 511", queue_t); end
    n_cmp++; if (out_ready !== 1'b0) begin n_err++;
      $display("FAIL wrap_stall_ready got %b want 0", out_ready); end
    n_cmp++; if (sq[0] !== 8'h5A) begin n_err++;
      $display("FAIL wrap_stall_slot0 got %h want 5a", sq[0]); end
    queue_s = 9'd2;
    step();
    n_cmp++; if (sq[511] !== 8'h03) begin n_err++;
      $display("FAIL wrap_slot511 got %h want 03", sq[511]); end
    step();
    n_cmp++; if (sq[0] !== 8'h04) begin n_err++;
      $display("FAIL wrap_slot0 got %h want 04", sq[0]); end
    n_cmp++; if (queue_t !== 9'd1) begin n_err++;
      $display("FAIL wrap_queue_t got %0d want 1", queue_t); end
    n_cmp++; if (bytes_written !== 32'd513) begin n_err++;
      $display("FAIL wrap_bytes got %0d want 513", bytes_written); end
    // queue_t + 1 == queue_s: still full while idle
    n_cmp++; if (out_ready !== 1'b0) begin n_err++;
      $display("FAIL wrap_idle_full_ready got %b want 0", out_ready); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    out_valid = 1'b1; out_word = 1'b1; out_data = 32'h1122_3344;
    step();
    out_valid = 1'b0; out_word = 1'b0; out_data = 32'h0;
    step();
    INITIALIZE = 1'b1;
    step();
    INITIALIZE = 1'b0;
    n_cmp++; if (queue_t !== 9'd0) begin n_err++;
      $display("FAIL mid_reset_queue_t got %0d want 0", queue_t); end
    n_cmp++; if (bytes_written !== 32'd0) begin n_err++;
      $display("FAIL mid_reset_bytes got %0d want 0", bytes_written); end
    n_cmp++; if (out_ready !== 1'b1) begin n_err++;
      $display("FAIL mid_reset_ready got %b want 1", out_ready); end
    step(); step(); step();
    n_cmp++; if (queue_t !== 9'd0 || bytes_written !== 32'd0) begin n_err++;
      $display("FAIL mid_reset_idle got queue_t %0d bytes %0d want 0 0", queue_t,
               bytes_written); end
    n_cmp++; if (sq[1] !== 8'h22 || sq[2] !== 8'h5A || sq[3] !== 8'h5A) begin n_err++;
      $display("FAIL mid_reset_slots got %h %h %h want 22 5a 5a", sq[1], sq[2], sq[3]); end
  endtask

  task automatic test_random_traffic();
    logic [7:0] exp_q [$];
    logic [7:0] want;
    logic       acc;
    int         sent;
    int         pushed;
    int         cyc;
    int         rate;
    sent = 0; pushed = 0; cyc = 0;
    do_reset();
    while ((sent < 200 || out_valid || exp_q.size() != 0) && cyc < 20000) begin
      @(negedge CLK);
      acc = out_valid && out_ready;
      step();
      cyc++;
      if (acc) begin
        if (out_word) begin
          exp_q.push_back(out_data[31:24]);
          exp_q.push_back(out_data[23:16]);
          exp_q.push_back(out_data[15:8]);
          exp_q.push_back(out_data[7:0]);
          pushed += 4;
        end else begin
          exp_q.push_back(out_data[7:0]);
          pushed += 1;
        end
        out_valid = 1'b0;
        sent++;
      end
      // Slow drain early on so the queue fills and stalls mid-word.
      rate = (cyc < 1500) ? 7 : 1;
      if (queue_s != queue_t && $urandom_range(0, rate) == 0) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rand_extra_byte got %h at slot %0d want none", sq[queue_s], queue_s);
        end else begin
          want = exp_q.pop_front();
          if (sq[queue_s] !== want) begin n_err++;
            $display("FAIL rand_stream slot %0d got %h want %h", queue_s, sq[queue_s], want); end
        end
        queue_s = queue_s + 9'd1;
      end
      if (!out_valid && sent < 200 && $urandom_range(0, 1) == 1) begin
        out_valid = 1'b1;
        out_word  = 1'($urandom_range(0, 1));
        out_data  = $urandom;
      end
    end
    n_cmp++; if (cyc >= 20000) begin n_err++;
      $display("FAIL rand_timeout got %0d cycles want < 20000", cyc); end
    n_cmp++; if (bytes_written !== 32'(pushed)) begin n_err++;
      $display("FAIL rand_bytes got %0d want %0d", bytes_written, pushed); end
    n_cmp++; if (queue_t !== queue_s) begin n_err++;
      $display("FAIL rand_empty got queue_t %0d want %0d", queue_t, queue_s); end
  endtask

  initial begin
    INITIALIZE = 1'b1;
    out_valid  = 1'b0;
    out_word   = 1'b0;
    out_data   = 32'h0;
    queue_s    = 9'd0;
    test_reset();
    test_byte();
    test_word();
    test_full();
    test_wrap_word();
    test_reset_mid_drain();
    test_random_traffic();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/output_queue_writer.md
# output_queue_writer

Front end of the UART output path: accepts byte- and word-sized output requests from the core's output instruction and serializes them into the 512-entry circular send queue. `output_manager` drains that queue, so this block owns the queue storage and the tail pointer `queue_t`. It reads back the head pointer `queue_s` to detect full and stalls the core through a ready handshake.

## Interface
- No parameters. Queue depth is fixed at 512 entries with a 9-bit pointer, matching `output_manager`.
- `CLK` in 1: sole clock; all state changes on its rising edge.
- `INITIALIZE` in 1: reset; synchronous, active-high.
- `out_valid` in 1: core presents an output request.
- `out_word` in 1: 1 = emit all 4 bytes of `out_data`, MSB first; 0 = emit `out_data[7:0]` only.
- `out_data` in 32: payload.
- `out_ready` out 1: request accepted on any cycle where `out_valid && out_ready`.
- `queue_s` in 9: head pointer from `output_manager`.
- `send_queue` out 8×512: queue storage, read by `output_manager`.
- `queue_t` out 9: tail pointer; the next free slot.
- `bytes_written` out 32: total bytes enqueued since reset; wraps mod 2^32.

## Operation
- Full condition: `full = (queue_t + 9'd1) == queue_s` (mod 512). Usable capacity is 511 bytes. Empty is `queue_t == queue_s`, which `output_manager` owns.
- Enqueue: writes `send_queue[queue_t]`, increments `queue_t` mod 512 (wraps 511→0) and increments `bytes_written`. At most one byte is enqueued per cycle, and never while `full`.
- States are IDLE and DRAIN. There is a 2-bit `remaining` counter and a 24-bit `pending` shift register.
- `out_ready = (state == IDLE) && !full`. It is combinational from registered state and `queue_s`.
- IDLE, accept with `out_word = 0`:
  - enqueue `out_data[7:0]`;
  - stay in IDLE.
- IDLE, accept with `out_word = 1`:
  - enqueue `out_data[31:24]`;
  - `pending <= out_data[23:0]`, `remaining <= 3`;
  - go to DRAIN.
- DRAIN, not full:
  - enqueue `pending[23:16]`;
  - `pending <= pending << 8`, `remaining <= remaining - 1`;
  - return to IDLE when `remaining == 1` (the last byte).
- DRAIN, full: hold. No write; `pending`, `remaining` and `queue_t` are unchanged.
- `out_valid` while `out_ready = 0`: ignored. The core must hold the request until accepted. `out_data` and `out_word` are sampled only on the accept cycle.
- Reset, applied in any state (including mid-DRAIN):
  - `queue_t = 0`, `state = IDLE`, `remaining = 0`, `bytes_written = 0`;
  - any undrained word bytes are discarded;
  - `send_queue` contents are not cleared (don't care; the queue reads as empty because `output_manager` also resets `queue_s` to 0).
- Outputs after reset: `out_ready = 1` (given `queue_s = 0`), `queue_t = 0`, `bytes_written = 0`.

## Timing
- Accept or drain at edge N: the `send_queue` entry and `queue_t` are both updated at edge N. `output_manager` therefore sees the new tail during cycle N+1, with data already stable in the slot.
- Word request: 4 consecutive enqueue cycles when space is available. `out_ready` is low for the 3 DRAIN cycles, so the next request can be accepted 4 cycles after the first.
- Byte requests: back-to-back, one per cycle.
- `queue_s` advancing on the same edge as an enqueue:
  - full is evaluated on the pre-edge `queue_s`, which is conservative: at worst one extra stall cycle, never an overwrite;
  - no combinational path from `queue_s` to any storage write enable other than through `full`.
- Full reached mid-word: DRAIN stalls. It resumes on the first cycle after `queue_s` moves, and bytes keep their order.
- Latency from an `out_valid` that is accepted to the first byte being visible to `output_manager`: 1 cycle.

## Test plan
- Reset, then byte 0x41 with `out_valid` for 1 cycle → `send_queue[0] = 0x41`, `queue_t = 1`, `bytes_written = 1`; `out_ready` stays 1.
- Word 0xDEADBEEF at `queue_t = 0` → slots 0..3 hold DE, AD, BE, EF on consecutive edges; `out_ready` is low for exactly 3 cycles; `queue_t = 4`.
- Hold `queue_s = 0` and enqueue 511 bytes → `queue_t = 511` and `out_ready = 0`. A 512th request is not accepted and `send_queue[511]` remains intact. Setting `queue_s = 1` → accept, `queue_t` wraps to 0.
- `queue_t = 509`, `queue_s = 0`, word 0x01020304 → 0x01 and 0x02 are written to slots 509 and 510, then stall. Bumping `queue_s` to 2 → 0x03 lands in slot 511 and 0x04 in slot 0; `queue_t = 1`.
- Assert `INITIALIZE` during DRAIN after 2 bytes of a word → next cycle `queue_t = 0`, `bytes_written = 0`, `out_ready = 1`; no further bytes are written.
- Random mixed byte/word traffic against an `output_manager` model draining at random rates → the received byte stream matches the request order exactly; no entry is ever written while `full`.
